// File: rtl/car_pose_ctrl.sv
// car_pose_ctrl: once-per-frame car pose integrator feeding the renderer.
//
// On every falling edge of i_V_sync (seen while idle) the driver buttons are
// latched and a six-step sequence updates heading, speed and position:
// STEER -> SPEED -> MOVE -> CLAMP -> PUBLISH. The new pose appears on the
// outputs six cycles after the tick and is held constant for the whole frame.
//
// Build option: define CAR_POSE_TURBO_EN to add the i_turbo input (double
// acceleration step and double forward cap while the latched turbo is high).
//
// Ports:
//   i_clk        system clock (shared with the VGA timing block)
//   i_rst_n      asynchronous reset, active low
//   i_V_sync     VGA vertical sync, active low, synchronous to i_clk
//   i_accel      accelerate button
//   i_brake      brake / reverse button
//   i_left       steer counter-clockwise
//   i_right      steer clockwise
//   i_turbo      turbo button (only with CAR_POSE_TURBO_EN)
//   o_x          signed integer pixel x
//   o_y          signed integer pixel y
//   o_angle      signed heading in degrees, -180..179, 0 = +x, 90 = screen up
//   o_pose_valid one-cycle pulse when a new pose is published
module car_pose_ctrl #(
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 623,
  parameter int Y_MIN      = 16,
  parameter int Y_MAX      = 463,
  parameter int ANGLE_STEP = 5,
  parameter int ACCEL      = 4,
  parameter int FRICTION   = 2,
  parameter int MAX_SPEED  = 64,
  parameter int MAX_REV    = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_V_sync,
  input  logic               i_accel,
  input  logic               i_brake,
  input  logic               i_left,
  input  logic               i_right,
`ifdef CAR_POSE_TURBO_EN
  input  logic               i_turbo,
`endif
  output logic signed [10:0] o_x,
  output logic signed [9:0]  o_y,
  output logic signed [8:0]  o_angle,
  output logic               o_pose_valid
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STEER   = 3'd1,
    ST_SPEED   = 3'd2,
    ST_MOVE    = 3'd3,
    ST_CLAMP   = 3'd4,
    ST_PUBLISH = 3'd5
  } state_t;

  localparam logic signed [9:0]  ANG_STEP_C = 10'(ANGLE_STEP);
  localparam logic signed [9:0]  ACC_C      = 10'(ACCEL);
  localparam logic signed [9:0]  FRIC_C     = 10'(FRICTION);
  localparam logic signed [9:0]  MAX_C      = 10'(MAX_SPEED);
  localparam logic signed [9:0]  REV_C      = 10'(-MAX_REV);
`ifdef CAR_POSE_TURBO_EN
  // Doubled forward cap would not fit the signed 8-bit speed; top out at +127.
  localparam logic signed [9:0]  TURBO_CAP_C  = (2 * MAX_SPEED > 127) ? 10'sd127 : 10'(2 * MAX_SPEED);
  localparam logic signed [9:0]  TURBO_STEP_C = 10'(2 * ACCEL);
`endif
  localparam logic signed [10:0] X_MIN_C  = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_C  = 11'(X_MAX);
  localparam logic signed [9:0]  Y_MIN_C  = 10'(Y_MIN);
  localparam logic signed [9:0]  Y_MAX_C  = 10'(Y_MAX);
  localparam logic signed [10:0] X_INIT_C = 11'(X_INIT);
  localparam logic signed [9:0]  Y_INIT_C = 10'(Y_INIT);

  // cos(-180 + 15k degrees) in Q2.8, rounded to nearest.
  function automatic logic signed [9:0] cos_rom(input logic [4:0] k);
    case (k)
      5'd0:  return -10'sd256;
      5'd1:  return -10'sd247;
      5'd2:  return -10'sd222;
      5'd3:  return -10'sd181;
      5'd4:  return -10'sd128;
      5'd5:  return -10'sd66;
      5'd6:  return 10'sd0;
      5'd7:  return 10'sd66;
      5'd8:  return 10'sd128;
      5'd9:  return 10'sd181;
      5'd10: return 10'sd222;
      5'd11: return 10'sd247;
      5'd12: return 10'sd256;
      5'd13: return 10'sd247;
      5'd14: return 10'sd222;
      5'd15: return 10'sd181;
      5'd16: return 10'sd128;
      5'd17: return 10'sd66;
      5'd18: return 10'sd0;
      5'd19: return -10'sd66;
      5'd20: return -10'sd128;
      5'd21: return -10'sd181;
      5'd22: return -10'sd222;
      5'd23: return -10'sd247;
      default: return 10'sd0;
    endcase
  endfunction

  // sin(a) = cos(a - 90): six sectors back in the same table.
  function automatic logic [4:0] sin_idx(input logic [4:0] k);
    if (k >= 5'd6) begin
      return k - 5'd6;
    end else begin
      return k + 5'd18;
    end
  endfunction

  state_t              state_r;
  logic                vsync_prev_r;
  logic                btn_accel_r, btn_brake_r, btn_left_r, btn_right_r;
`ifdef CAR_POSE_TURBO_EN
  logic                btn_turbo_r;
`endif
  logic signed [8:0]   angle_r;
  logic signed [7:0]   speed_r;
  logic signed [14:0]  x_acc_r;   // Q11.4
  logic signed [13:0]  y_acc_r;   // Q10.4

  logic                tick_s;
  logic signed [9:0]   ang_sum_s;
  logic signed [8:0]   angle_next_s;
  logic signed [9:0]   spd_s, cap_s, step_s;
  logic signed [7:0]   spd_next_s;
  logic signed [9:0]   ang_off_s, sec_raw_s;
  logic [4:0]          sector_s;
  logic signed [9:0]   cos_s, sin_s;
  logic signed [17:0]  prod_x_s, prod_y_s;
  logic signed [9:0]   dx_s, dy_s;
  logic signed [10:0]  x_int_s;
  logic signed [9:0]   y_int_s;

  assign tick_s  = vsync_prev_r & ~i_V_sync;
  assign x_int_s = x_acc_r[14:4];
  assign y_int_s = y_acc_r[13:4];

  // Heading update with wrap into -180..179.
  always_comb begin
    ang_sum_s = 10'(angle_r);
    if (btn_left_r && !btn_right_r) begin
      ang_sum_s = 10'(angle_r) + ANG_STEP_C;
    end else if (btn_right_r && !btn_left_r) begin
      ang_sum_s = 10'(angle_r) - ANG_STEP_C;
    end else begin
      ang_sum_s = 10'(angle_r);
    end
    if (ang_sum_s > 10'sd179) begin
      angle_next_s = 9'(ang_sum_s - 10'sd360);
    end else if (ang_sum_s < -10'sd180) begin
      angle_next_s = 9'(ang_sum_s + 10'sd360);
    end else begin
      angle_next_s = 9'(ang_sum_s);
    end
  end

  // Speed update: accelerate, brake/reverse or coast toward zero.
  always_comb begin
`ifdef CAR_POSE_TURBO_EN
    if (btn_turbo_r) begin
      cap_s  = TURBO_CAP_C;
      step_s = TURBO_STEP_C;
    end else begin
      cap_s  = MAX_C;
      step_s = ACC_C;
    end
`else
    cap_s  = MAX_C;
    step_s = ACC_C;
`endif
    spd_s = 10'(speed_r);
    if (btn_accel_r && !btn_brake_r) begin
      if (spd_s > cap_s) begin
        // Above the current cap (turbo just released): decay, never snap down.
        spd_next_s = (spd_s - FRIC_C < cap_s) ? 8'(cap_s) : 8'(spd_s - FRIC_C);
      end else begin
        spd_next_s = (spd_s + step_s > cap_s) ? 8'(cap_s) : 8'(spd_s + step_s);
      end
    end else if (btn_brake_r && !btn_accel_r) begin
      spd_next_s = (spd_s - ACC_C < REV_C) ? 8'(REV_C) : 8'(spd_s - ACC_C);
    end else if (spd_s > FRIC_C) begin
      spd_next_s = 8'(spd_s - FRIC_C);
    end else if (spd_s < -FRIC_C) begin
      spd_next_s = 8'(spd_s + FRIC_C);
    end else begin
      spd_next_s = 8'sd0;
    end
  end

  // Direction sector lookup and per-frame displacement (floor via >>>).
  always_comb begin
    ang_off_s = 10'(angle_r) + 10'sd187;
    sec_raw_s = ang_off_s / 10'sd15;
    if (sec_raw_s >= 10'sd24) begin
      sector_s = 5'd0;
    end else begin
      sector_s = 5'(sec_raw_s);
    end
    cos_s    = cos_rom(sector_s);
    sin_s    = cos_rom(sin_idx(sector_s));
    prod_x_s = 18'(speed_r) * 18'(cos_s);
    prod_y_s = 18'(speed_r) * 18'(sin_s);
    dx_s     = 10'(prod_x_s >>> 8);
    dy_s     = 10'(prod_y_s >>> 8);
  end

  // Frame sequencer: owns all pose state and the registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      vsync_prev_r <= 1'b1;
      btn_accel_r  <= 1'b0;
      btn_brake_r  <= 1'b0;
      btn_left_r   <= 1'b0;
      btn_right_r  <= 1'b0;
`ifdef CAR_POSE_TURBO_EN
      btn_turbo_r  <= 1'b0;
`endif
      angle_r      <= 9'sd0;
      speed_r      <= 8'sd0;
      x_acc_r      <= {X_INIT_C, 4'b0000};
      y_acc_r      <= {Y_INIT_C, 4'b0000};
      o_x          <= X_INIT_C;
      o_y          <= Y_INIT_C;
      o_angle      <= 9'sd0;
      o_pose_valid <= 1'b0;
    end else begin
      vsync_prev_r <= i_V_sync;
      o_pose_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (tick_s) begin
            btn_accel_r <= i_accel;
            btn_brake_r <= i_brake;
            btn_left_r  <= i_left;
            btn_right_r <= i_right;
`ifdef CAR_POSE_TURBO_EN
            btn_turbo_r <= i_turbo;
`endif
            state_r     <= ST_STEER;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_STEER: begin
          angle_r <= angle_next_s;
          state_r <= ST_SPEED;
        end
        ST_SPEED: begin
          speed_r <= spd_next_s;
          state_r <= ST_MOVE;
        end
        ST_MOVE: begin
          x_acc_r <= x_acc_r + 15'(dx_s);
          y_acc_r <= y_acc_r - 14'(dy_s);
          state_r <= ST_CLAMP;
        end
        ST_CLAMP: begin
          if (x_int_s < X_MIN_C) begin
            x_acc_r <= {X_MIN_C, 4'b0000};
          end else if (x_int_s > X_MAX_C) begin
            x_acc_r <= {X_MAX_C, 4'b0000};
          end else begin
            x_acc_r <= x_acc_r;
          end
          if (y_int_s < Y_MIN_C) begin
            y_acc_r <= {Y_MIN_C, 4'b0000};
          end else if (y_int_s > Y_MAX_C) begin
            y_acc_r <= {Y_MAX_C, 4'b0000};
          end else begin
            y_acc_r <= y_acc_r;
          end
          // Hitting any wall kills the car's speed.
          if ((x_int_s < X_MIN_C) || (x_int_s > X_MAX_C) ||
              (y_int_s < Y_MIN_C) || (y_int_s > Y_MAX_C)) begin
            speed_r <= 8'sd0;
          end else begin
            speed_r <= speed_r;
          end
          state_r <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          o_x          <= x_int_s;
          o_y          <= y_int_s;
          o_angle      <= angle_r;
          o_pose_valid <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_car_pose_ctrl.sv
// Self-checking bench for car_pose_ctrl: directed frame sequences followed by
// random button frames, each compared with a real-arithmetic pose model.
module tb_car_pose_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               v_sync;
  logic               accel, brake, left, right;
  logic signed [10:0] o_x;
  logic signed [9:0]  o_y;
  logic signed [8:0]  o_angle;
  logic               o_pose_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference pose: angle in degrees, speed in 1/16 px/frame, x/y in 1/16 px.
  int m_angle, m_speed, m_x, m_y;
  int clamp_frames = 0;

  always #5 clk = ~clk;

  car_pose_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_V_sync     (v_sync),
    .i_accel      (accel),
    .i_brake      (brake),
    .i_left       (left),
    .i_right      (right),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_angle      (o_angle),
    .o_pose_valid (o_pose_valid)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int trig_q8(input int deg, input bit want_sin);
    real rad, v;
    rad = real'(deg) * 3.14159265358979 / 180.0;
    v   = want_sin ? 256.0 * $sin(rad) : 256.0 * $cos(rad);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int floor_div(input int num, input int den);
    return $rtoi($floor(real'(num) / real'(den)));
  endfunction

  task automatic model_reset();
    m_angle = 0;
    m_speed = 0;
    m_x     = 320 * 16;
    m_y     = 240 * 16;
  endtask

  task automatic model_frame(input bit a, input bit b, input bit l, input bit r);
    int k, c, s, xi, yi;
    bit hit;
    if (l && !r)      m_angle += 5;
    else if (r && !l) m_angle -= 5;
    if (m_angle > 179)       m_angle -= 360;
    else if (m_angle < -180) m_angle += 360;
    if (a && !b)          m_speed = (m_speed + 4 > 64) ? 64 : m_speed + 4;
    else if (b && !a)     m_speed = (m_speed - 4 < -32) ? -32 : m_speed - 4;
    else if (m_speed > 2) m_speed -= 2;
    else if (m_speed < -2) m_speed += 2;
    else                  m_speed = 0;
    k = ((m_angle + 187) / 15) % 24;
    c = trig_q8(-180 + 15 * k, 1'b0);
    s = trig_q8(-180 + 15 * k, 1'b1);
    m_x += floor_div(m_speed * c, 256);
    m_y -= floor_div(m_speed * s, 256);
    hit = 1'b0;
    xi = floor_div(m_x, 16);
    yi = floor_div(m_y, 16);
    if (xi < 16)  begin m_x = 16 * 16;  hit = 1'b1; end
    if (xi > 623) begin m_x = 623 * 16; hit = 1'b1; end
    if (yi < 16)  begin m_y = 16 * 16;  hit = 1'b1; end
    if (yi > 463) begin m_y = 463 * 16; hit = 1'b1; end
    if (hit) begin
      m_speed = 0;
      clamp_frames++;
    end
  endtask

  // One frame: tick, scrambled buttons after latching, a spurious tick while
  // busy, then the publish-timing and pose checks.
  task automatic run_frame(input bit a, input bit b, input bit l, input bit r);
    @(negedge clk);
    accel = a; brake = b; left = l; right = r;
    v_sync = 1'b0;
    @(posedge clk); #1;
    accel = ~a; brake = ~b; left = ~l; right = r;
    @(posedge clk); #1; v_sync = 1'b1;
    @(posedge clk); #1; v_sync = 1'b0;
    @(posedge clk); #1; v_sync = 1'b1;
    @(posedge clk); #1;
    check_val("valid_before_e6", int'(o_pose_valid), 0);
    model_frame(a, b, l, r);
    @(posedge clk); #1;
    check_val("valid_at_e6", int'(o_pose_valid), 1);
    check_val("x", int'(o_x), floor_div(m_x, 16));
    check_val("y", int'(o_y), floor_div(m_y, 16));
    check_val("angle", int'(o_angle), m_angle);
    @(posedge clk); #1;
    check_val("valid_after_e6", int'(o_pose_valid), 0);
    accel = 1'b0; brake = 1'b0; left = 1'b0; right = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_in_move();
    int pulses;
    pulses = 0;
    @(negedge clk);
    accel = 1'b1; left = 1'b1;
    v_sync = 1'b0;
    @(posedge clk); #1; v_sync = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_x", int'(o_x), 320);
    check_val("rst_mid_y", int'(o_y), 240);
    check_val("rst_mid_angle", int'(o_angle), 0);
    check_val("rst_mid_valid", int'(o_pose_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (o_pose_valid) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    accel = 1'b0; left = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (o_pose_valid) pulses++;
    end
    check_val("rst_mid_no_pulse", pulses, 0);
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    v_sync = 1'b1;
    accel = 1'b0; brake = 1'b0; left = 1'b0; right = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_x", int'(o_x), 320);
    check_val("reset_y", int'(o_y), 240);
    check_val("reset_angle", int'(o_angle), 0);
    check_val("reset_valid", int'(o_pose_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Idle frames: pose stays at reset values.
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("idle_x", int'(o_x), 320);

    // Acceleration ramp to the forward cap.
    for (int i = 0; i < 16; i++) run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("accel16_x", int'(o_x), 354);
    check_val("accel16_y", int'(o_y), 240);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("accel17_x", int'(o_x), 358);

    // Coast to rest, then reverse to the reverse cap, then coast again.
    for (int i = 0; i < 32; i++) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("coast_speed_model", m_speed, 0);
    for (int i = 0; i < 10; i++) run_frame(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Steering wrap in both directions.
    for (int i = 0; i < 37; i++) run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("left37_angle", int'(o_angle), -175);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("right_to_m180", int'(o_angle), -180);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("right_wrap_175", int'(o_angle), 175);
    run_frame(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset during MOVE aborts the frame; the next tick works normally.
    reset_in_move();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("post_rst_angle", int'(o_angle), 5);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Drive into the right wall at full speed.
    for (int i = 0; i < 90; i++) begin
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("xmax_bound", int'(o_x <= 11'sd623), 1);
    end
    check_val("right_wall_x", int'(o_x), 623);

    // Random driving.
    for (int i = 0; i < 120; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/car_pose_ctrl.md
Name: car_pose_ctrl

Overview:
- Upstream of the renderer top level. Produces the car pose (o_x, o_y, o_angle) that drives the renderer's i_x / i_y / i_angle.
- Once per video frame, on the VGA vertical-sync falling edge, reads driver buttons and updates heading, speed and position in fixed point.
- Publishes the new pose atomically, so the pose is constant for a whole frame.

Parameters:
- X_INIT, 320, reset x pixel
- Y_INIT, 240, reset y pixel
- X_MIN / X_MAX, 16 / 623, inclusive x clamp bounds (integer pixels)
- Y_MIN / Y_MAX, 16 / 463, inclusive y clamp bounds
- ANGLE_STEP, 5, degrees added or removed per steering frame
- ACCEL, 4, speed change per frame for accel or brake (Q4.4, 0.25 px/frame)
- FRICTION, 2, speed decay per frame toward 0 when coasting (Q4.4)
- MAX_SPEED, 64, forward speed cap (Q4.4, 4 px/frame)
- MAX_REV, 32, reverse speed cap magnitude (Q4.4)

Ports:
- i_clk  in  1  system clock (same clock as the VGA block)
- i_rst_n  in  1  asynchronous reset, active low
- i_V_sync  in  1  VGA vertical sync, active low, synchronous to i_clk
- i_accel  in  1  accelerate button, active high
- i_brake  in  1  brake/reverse button
- i_left  in  1  steer counter-clockwise
- i_right  in  1  steer clockwise
- o_x  out  11  signed pixel x, integer part of the internal x accumulator
- o_y  out  10  signed pixel y
- o_angle  out  9  signed heading in degrees, range -180..179; 0 = +x, 90 = screen up
- o_pose_valid  out  1  one-cycle pulse when a new pose is published

Behaviour:
- Reset: o_x=X_INIT, o_y=Y_INIT, o_angle=0, o_pose_valid=0.
- Reset also clears: internal speed=0; accumulators to X_INIT/Y_INIT with zero fraction; FSM=IDLE; sync history register=1.
- Reset asserted mid-update aborts the update; nothing is published.
- Tick: registered previous i_V_sync is 1 and current i_V_sync is 0 (cycle E). Buttons are latched in cycle E.
- Ticks arriving outside IDLE are ignored.
- FSM: IDLE -> STEER -> SPEED -> MOVE -> CLAMP -> PUBLISH -> IDLE, one cycle per state.
- Latency: new outputs and o_pose_valid=1 are visible in cycle E+6. The pulse lasts exactly 1 cycle. Outputs otherwise hold.
- STEER:
  - left only: angle += ANGLE_STEP; right only: angle -= ANGLE_STEP; both or neither: unchanged.
  - Wrap: result >179 subtract 360; result < -180 add 360.
  - Steering is independent of speed.
- SPEED (signed 8-bit, Q4.4):
  - accel only: +ACCEL, saturate at MAX_SPEED.
  - brake only: -ACCEL, saturate at -MAX_REV.
  - both or neither: move toward 0 by FRICTION; if |speed| < FRICTION, speed = 0 (no sign overshoot).
- MOVE: sector index k = floor((angle+187)/15) mod 24.
  - ROM cos/sin: signed 10-bit Q2.8 at -180+15k degrees, 256 = 1.0, rounded to nearest.
  - Accumulators are signed Q11.4 (x) and Q10.4 (y).
  - x_acc += (speed*cos)>>>8; y_acc -= (speed*sin)>>>8.
  - Arithmetic shift, floor toward -infinity. The uses the speed value computed this frame.
- CLAMP: clamp the integer part to [X_MIN,X_MAX] and [Y_MIN,Y_MAX].
  - A clamped coordinate gets fraction=0.
  - Any clamp in either axis forces speed=0.
- PUBLISH: o_x, o_y = integer parts; o_angle = new angle; o_pose_valid=1.

Optional Feature:
- Macro CAR_POSE_TURBO_EN.
- Defined: adds input port i_turbo (1 bit). While the latched i_turbo=1, the accel step is 2*ACCEL and the forward cap is 2*MAX_SPEED. Reverse is unchanged. Speed above MAX_SPEED with turbo released decays by FRICTION per frame; it is not clipped instantly.
- Undefined: no i_turbo port; behaviour exactly as above.

Test Plan:
- Reset, then 3 frames with no buttons -> o_x=320, o_y=240, o_angle=0; one o_pose_valid pulse per frame at E+6.
- i_accel held 16 frames at angle 0 -> speed reaches 64; o_x=354 (sum 4..64 step 4 = 544/16), o_y=240. A 17th frame -> o_x=358, speed stays 64.
- i_left held 37 frames from angle 0 -> o_angle=-175 after frame 37 (wrap). Then i_right 1 frame from angle -180 -> 175.
- Speed 64 then no buttons -> speed reaches 0 after exactly 32 frames. Brake from 0 for 10 frames -> speed=-32 (capped at -MAX_REV).
- Angle 0, full speed toward the right edge -> o_x never exceeds 623. The frame that clamps forces speed=0; the next accel frame moves +0.25 px.
- Assert i_rst_n low in the MOVE cycle -> outputs return to reset values immediately; no o_pose_valid pulse. Next tick after release processes normally.
